// File: rtl/inv_mixcolumns_if.sv
// rtl/inv_mixcolumns_if.sv - start/done handshake and state bus for the InvMixColumns engine
interface inv_mixcolumns_if;
   logic         ena;
   logic [127:0] state_in;
   logic [127:0] state_out;
   logic         done;
   logic         busy;

   modport master (
      output ena,
      output state_in,
      input  state_out,
      input  done,
      input  busy
   );

   modport slave (
      input  ena,
      input  state_in,
      output state_out,
      output done,
      output busy
   );
endinterface

// File: rtl/inv_mixcolumns.sv
// rtl/inv_mixcolumns.sv - iterative AES InvMixColumns engine; INV_MIXCOLUMNS_UNROLL_EN selects four parallel column multipliers
module inv_mixcolumns (
   input  logic              clk,
   input  logic              rst,
   inv_mixcolumns_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t         fsm;
   logic [127:0] work;
   logic [127:0] result;
   logic [127:0] state_out_r;
   logic         done_r;
   logic         busy_r;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse MixColumns on one column; byte r of the column is row r.
   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[8*i +: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
      end
      inv_col = r;
   endfunction

`ifdef INV_MIXCOLUMNS_UNROLL_EN
   logic [127:0] all_cols;

   assign all_cols = {inv_col(work[127:96]), inv_col(work[95:64]),
                      inv_col(work[63:32]),  inv_col(work[31:0])};

   // Control FSM with all four columns computed in the single CALC cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm         <= IDLE;
         work        <= '0;
         result      <= '0;
         state_out_r <= '0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (fsm)
            IDLE: begin
               if (bus.ena) begin
                  work   <= bus.state_in;
                  busy_r <= 1'b1;
                  fsm    <= CALC;
               end
            end
            CALC: begin
               result <= all_cols;
               fsm    <= DONE;
            end
            DONE: begin
               state_out_r <= result;
               done_r      <= 1'b1;
               busy_r      <= 1'b0;
               fsm         <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
`else
   logic [1:0]  col;
   logic [31:0] col_out;

   // The single shared multiplier is steered by the column counter.
   assign col_out = inv_col(work[{col, 5'b00000} +: 32]);

   // Control FSM walking one column per CALC cycle into the result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm         <= IDLE;
         col         <= 2'd0;
         work        <= '0;
         result      <= '0;
         state_out_r <= '0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (fsm)
            IDLE: begin
               if (bus.ena) begin
                  work   <= bus.state_in;
                  col    <= 2'd0;
                  busy_r <= 1'b1;
                  fsm    <= CALC;
               end
            end
            CALC: begin
               result[{col, 5'b00000} +: 32] <= col_out;
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  fsm <= DONE;
               end
            end
            DONE: begin
               state_out_r <= result;
               done_r      <= 1'b1;
               busy_r      <= 1'b0;
               fsm         <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
`endif

   assign bus.state_out = state_out_r;
   assign bus.done      = done_r;
   assign bus.busy      = busy_r;

endmodule
